// File: rtl/xylo_note_sequencer.sv
// Plays a 16-entry melody (Tom/Notas/dur) into the xylophone note decoder.
// Optional XYLO_LOOP_EN: loop from entry 0 after the final entry instead of finishing with done.
module xylo_note_sequencer #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] last_addr,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [5:0] wr_data,
    output logic       Tom,
    output logic [2:0] Notas,
    output logic       note_valid,
    output logic       note_start,
    output logic       busy,
    output logic       done
);

    typedef enum logic {IDLE, PLAY} state_t;

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    logic [5:0]  mem_q [16];

    state_t      state_q, state_d;
    logic [3:0]  addr_q, addr_d;
    logic [3:0]  last_q, last_d;
    logic        tom_q, tom_d;
    logic [2:0]  notas_q, notas_d;
    logic [1:0]  dur_q, dur_d;
    logic [15:0] presc_q, presc_d;
    logic [1:0]  beat_q, beat_d;
    logic        note_start_q, note_start_d;
    logic        done_q, done_d;

    logic [3:0]  fetch_addr;
    logic [5:0]  fetch_entry;

    // NOTE: the pattern memory has no reset; contents must survive rst, and
    // leaving it out of the reset net lets it map onto plain storage.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Entry for the note that would begin at the next edge; a same-edge write is forwarded.
    always_comb begin
        fetch_addr  = (state_q == PLAY && addr_q != last_q) ? addr_q + 4'd1 : 4'd0;
        fetch_entry = (wr_en && wr_addr == fetch_addr) ? wr_data : mem_q[fetch_addr];
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        last_d       = last_q;
        tom_d        = tom_q;
        notas_d      = notas_q;
        dur_d        = dur_q;
        presc_d      = presc_q;
        beat_d       = beat_q;
        note_start_d = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d      = PLAY;
                    addr_d       = 4'd0;
                    last_d       = last_addr;
                    tom_d        = fetch_entry[5];
                    notas_d      = fetch_entry[4:2];
                    dur_d        = fetch_entry[1:0];
                    presc_d      = '0;
                    beat_d       = '0;
                    note_start_d = 1'b1;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    tom_d   = 1'b0;
                    notas_d = '0;
                    dur_d   = '0;
                    presc_d = '0;
                    beat_d  = '0;
                end else if (presc_q != PRESC_MAX) begin
                    presc_d = presc_q + 16'd1;
                end else if (beat_q != dur_q) begin
                    presc_d = '0;
                    beat_d  = beat_q + 2'd1;
                end else begin
                    presc_d = '0;
                    beat_d  = '0;
`ifdef XYLO_LOOP_EN
                    addr_d       = fetch_addr;
                    tom_d        = fetch_entry[5];
                    notas_d      = fetch_entry[4:2];
                    dur_d        = fetch_entry[1:0];
                    note_start_d = 1'b1;
`else
                    if (addr_q != last_q) begin
                        addr_d       = fetch_addr;
                        tom_d        = fetch_entry[5];
                        notas_d      = fetch_entry[4:2];
                        dur_d        = fetch_entry[1:0];
                        note_start_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        addr_d  = '0;
                        tom_d   = 1'b0;
                        notas_d = '0;
                        dur_d   = '0;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            last_q       <= '0;
            tom_q        <= 1'b0;
            notas_q      <= '0;
            dur_q        <= '0;
            presc_q      <= '0;
            beat_q       <= '0;
            note_start_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            last_q       <= last_d;
            tom_q        <= tom_d;
            notas_q      <= notas_d;
            dur_q        <= dur_d;
            presc_q      <= presc_d;
            beat_q       <= beat_d;
            note_start_q <= note_start_d;
            done_q       <= done_d;
        end
    end

    assign Tom        = tom_q;
    assign Notas      = notas_q;
    assign note_valid = (state_q == PLAY);
    assign busy       = (state_q == PLAY);
    assign note_start = note_start_q;
    assign done       = done_q;

endmodule
